// File: rtl/la_pkg.sv
// Shared constants and types for the logic-analyzer capture path.
package la_pkg;

  typedef logic [1:0] proto_id_t;

  localparam proto_id_t PROTO_UART = 2'd0;
  localparam proto_id_t PROTO_SPI  = 2'd1;
  localparam proto_id_t PROTO_I2C  = 2'd2;
  localparam proto_id_t PROTO_NONE = 2'd3;

  localparam int FIFO_WORD_W = 16;
  localparam int ID_LSB      = 14;
  localparam int TS_LSB      = 8;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACTIVE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/la_rr_arbiter.sv
// Combinational round-robin pick over pending[], searching upward from rr_ptr with wrap.
// Zero latency; grants whenever any bit of pending is set.
module la_rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] pending,
  input  logic [1:0]      rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic            any_grant
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    any_grant = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any_grant && pending[idx]) begin
        grant[idx] = 1'b1;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoder_fifo_arbiter.sv
// Merges UART/SPI/I2C decoder strobes into the capture FIFO as tagged words; optional timestamps via ARB_TIMESTAMP_EN.
// Strobe to fifo_wr_en is 2 cycles minimum, one word per cycle sustained.
// Backpressure: no grant while fifo_full or while the in-flight write takes the last afull slot; new strobes on busy slots are dropped.
module decoder_fifo_arbiter
  import la_pkg::*;
#(
  parameter int NREQ   = 3,
  parameter int DATA_W = 8,
  parameter int TS_W   = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic                     fifo_full,
  input  logic                     fifo_afull,
  output logic                     fifo_wr_en,
  output logic [FIFO_WORD_W-1:0]   fifo_wr_data,
  output logic [1:0]               grant_id,
  output logic [NREQ-1:0]          drop_flags,
  input  logic                     clear_drops
);

  arb_state_t state_q, state_d;
  logic arb_active;

  logic [NREQ-1:0] pending_q, pending_d, grant_oh, gnt, load, drop;
  logic [NREQ-1:0][DATA_W-1:0] hold_data_q;
  logic [1:0] rr_ptr_q, gnt_idx, rr_next;
  logic any_req, grant_ok;
  logic [TS_W-1:0] gnt_ts;
  logic [FIFO_WORD_W-1:0] word_d;

  la_rr_arbiter #(.NREQ(NREQ)) u_rr (
    .pending   (pending_q),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant_oh),
    .any_grant (any_req)
  );

  // A write already in flight consumes the single slot left when afull is high.
  assign grant_ok = arb_active && enable && any_req && !fifo_full && !(fifo_wr_en && fifo_afull);
  assign gnt      = grant_oh & {NREQ{grant_ok}};

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (grant_oh[i]) gnt_idx = 2'(i);
  end

  assign rr_next = (int'(gnt_idx) == NREQ - 1) ? 2'd0 : gnt_idx + 2'd1;

  // A slot being granted this cycle may be refilled by a same-cycle strobe.
  assign load      = {NREQ{enable}} & req_valid & (~pending_q | gnt);
  assign drop      = {NREQ{enable}} & req_valid & pending_q & ~gnt;
  assign pending_d = enable ? ((pending_q & ~gnt) | load) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (|pending_d) state_d = ARB_ACTIVE;
      ARB_ACTIVE: if (!enable || !(|pending_d)) state_d = ARB_IDLE;
      default:    state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    arb_active = (state_q == ARB_ACTIVE);
  end

`ifdef ARB_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q;
  logic [NREQ-1:0][TS_W-1:0] hold_ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_q  <= '0;
      hold_ts_q <= '0;
    end else begin
      if (enable) ts_cnt_q <= ts_cnt_q + 1'b1;
      for (int i = 0; i < NREQ; i++)
        if (load[i]) hold_ts_q[i] <= ts_cnt_q;
    end
  end

  assign gnt_ts = hold_ts_q[gnt_idx];
`else
  assign gnt_ts = '0;
`endif

  always_comb begin
    word_d                           = '0;
    word_d[FIFO_WORD_W-1:ID_LSB]     = gnt_idx;
    word_d[TS_LSB +: TS_W]           = gnt_ts;
    word_d[DATA_W-1:0]               = hold_data_q[gnt_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q    <= '0;
      hold_data_q  <= '0;
      rr_ptr_q     <= PROTO_UART;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      grant_id     <= '0;
      drop_flags   <= '0;
    end else begin
      pending_q <= pending_d;
      for (int i = 0; i < NREQ; i++)
        if (load[i]) hold_data_q[i] <= req_data[i*DATA_W +: DATA_W];
      fifo_wr_en <= grant_ok;
      if (grant_ok) begin
        fifo_wr_data <= word_d;
        grant_id     <= gnt_idx;
        rr_ptr_q     <= rr_next;
      end
      drop_flags <= clear_drops ? '0 : (drop_flags | drop);
    end
  end

endmodule

// File: doc/decoder_fifo_arbiter.md
Name: decoder_fifo_arbiter

Overview:
Shares the single write port of the capture FIFO between the UART, SPI and I2C decoders. Each decoder's one-cycle valid strobe is latched into a per-requester holding register. A round-robin arbiter then drains the holding registers into the FIFO as 16-bit tagged words. The block sits between the decoder instances and the FIFO in the top-level analyzer. It replaces the single-protocol write mux so that all three decoders can log at the same time.

Parameters:
NREQ, 3, number of requesters; index = protocol id (0 UART, 1 SPI, 2 I2C); max 4
DATA_W, 8, decoded byte width
TS_W, 6, timestamp field width; word width = 2 + TS_W + DATA_W = 16

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  arbiter active; low flushes pending entries
req_valid  in  NREQ  one-cycle strobes from the decoders
req_data  in  NREQ*DATA_W  decoder bytes; requester i occupies bits [i*DATA_W +: DATA_W]
fifo_full  in  1  FIFO cannot accept a write this cycle
fifo_afull  in  1  FIFO has exactly one free entry
fifo_wr_en  out  1  registered write strobe
fifo_wr_data  out  16  registered word {id[1:0], ts[TS_W-1:0], data[DATA_W-1:0]}
grant_id  out  2  id of the most recent write
drop_flags  out  NREQ  sticky per-requester overrun flags
clear_drops  in  1  synchronous clear of drop_flags

Behaviour:
- Reset: all outputs 0; pending[] = 0; rr_ptr = 0; timestamp counter = 0.
- Capture:
  - req_valid[i] with pending[i]=0, or with requester i granted in the same cycle, loads hold_data[i], hold_ts[i] and sets pending[i] at the next edge.
  - req_valid[i] with pending[i]=1 and no grant to i in that cycle drops the new byte and sets drop_flags[i]. The held byte is kept.
- Grant condition: enable && |pending && !fifo_full && !(fifo_wr_en && fifo_afull).
  - The last term accounts for the write already in flight.
- Arbitration: combinational round-robin over pending[]. The search starts at rr_ptr and wraps modulo NREQ; one grant per cycle.
- On grant g, at the next edge:
  - fifo_wr_en = 1 for exactly one cycle; fifo_wr_data = {g, hold_ts[g], hold_data[g]}; grant_id = g.
  - pending[g] clears, unless reloaded by a same-cycle req_valid[g].
  - rr_ptr = (g+1) mod NREQ.
- No grant: fifo_wr_en = 0 at the next edge. fifo_wr_data and grant_id hold their values.
- Latency: strobe in cycle N gives fifo_wr_en high in cycle N+2 at the earliest. Sustained throughput is one word per cycle.
- Two-state FSM:
  - IDLE (no pending) -> ARB when any pending.
  - ARB -> IDLE when the last pending entry is granted and no new capture arrives.
  - ARB -> IDLE on enable=0. This also clears pending[] at the next edge, with no write issued. drop_flags are kept.
  - Requests arriving while enable=0 are ignored and do not set drop flags.
- clear_drops has priority over a same-cycle drop set.
- Reset asserted mid-burst: immediate clear, with no partial write.
- Write id field is 2 bits; requester index is zero-extended.

Optional Feature:
ARB_TIMESTAMP_EN:
- Defined: a TS_W-bit free-running cycle counter runs while enable=1 and wraps from 2^TS_W-1 to 0. It is sampled into hold_ts[i] at capture.
- Undefined: the ts field is constant 0; the counter and hold_ts registers are not instantiated.

Decomposition:
- Shared package la_pkg:
  - proto id constants PROTO_UART=0, PROTO_SPI=1, PROTO_I2C=2, PROTO_NONE=3
  - FIFO_WORD_W=16
  - field offsets ID_LSB=14, TS_LSB=8
- Sub-module la_rr_arbiter: NREQ-wide pending vector plus rr_ptr in, one-hot grant plus any_grant out. Purely combinational.

Test Plan:
1. ARB_TIMESTAMP_EN undefined. req_valid=001 with data 0x55 in cycle N -> fifo_wr_en high in cycle N+2 only, fifo_wr_data=0x0055, grant_id=0.
2. req_valid=111 in one cycle with data 0x11/0x22/0x33 -> writes in consecutive cycles 0x0011, 0x4022, 0x8033; rr_ptr ends at 0.
3. fifo_full=1, UART strobe 0xAA then 0xBB -> no writes, drop_flags=001. Release full -> single write 0x00AA. clear_drops -> drop_flags=000.
4. fifo_afull=1 during a write while SPI and I2C are pending -> no write in the following cycle. Deassert afull -> remaining writes resume.
5. SPI and I2C pending, enable dropped for one cycle -> pending flushed, no writes. Re-enable -> idle outputs.
6. ARB_TIMESTAMP_EN defined, rst_n pulsed mid-burst -> outputs 0 immediately. Strobe 70 cycles after release -> ts field = 70 mod 64 = 6.
